// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load/store unit, IDLE/REQ/WAIT handshake to a word-wide data port.
// Optional LSU_MISALIGN_CHECK_EN: trap misaligned H/W accesses instead of issuing them.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  offset_q;
  logic [2:0]  size_q;

  logic        is_b, is_h, is_w;
  logic        size_legal, misaligned;
  logic        start, immediate, completion;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] byte_sh, half_sh;

  // funct3: 0/4 byte, 1/5 half, 2 word; 3, 6, 7 illegal
  assign is_b = (lsu_size_i[1:0] == 2'b00);
  assign is_h = (lsu_size_i[1:0] == 2'b01);
  assign is_w = (lsu_size_i == 3'b010);
  assign size_legal = is_b | is_h | is_w;

  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    unique case (1'b1)
      is_b: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_data_i[7:0]}};
      end
      is_h: begin
        be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d = {2{lsu_data_i[15:0]}};
      end
      is_w: begin
        be_d    = 4'b1111;
        wdata_d = lsu_data_i;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = (is_h & lsu_addr_i[0]) |
                      (is_w & (lsu_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign start      = (state_q == IDLE) & lsu_req_i &
                      size_legal & ~misaligned;
  assign immediate  = (state_q == IDLE) & lsu_req_i &
                      (~size_legal | misaligned);
  assign completion = (state_q == WAIT) & data_rvalid_i;

  assign byte_sh = data_rdata_i >> {offset_q, 3'b000};
  assign half_sh = data_rdata_i >> {offset_q[1], 4'b0000};

  always_comb begin
    state_d          = state_q;
    data_req_o       = (state_q == REQ);
    lsu_misaligned_o = immediate & misaligned & ~rst_i;
    lsu_data_o       = 32'h0;
    if (rst_i)
      lsu_stall_req_o = lsu_req_i;
    else
      lsu_stall_req_o = lsu_req_i & ~completion & ~immediate;

    unique case (state_q)
      IDLE: if (start)         state_d = REQ;
      REQ:  if (data_gnt_i)    state_d = WAIT;
      WAIT: if (data_rvalid_i) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase

    if (completion && !data_we_o && !rst_i) begin
      unique case (1'b1)
        (size_q == 3'b000): lsu_data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
        (size_q == 3'b100): lsu_data_o = {24'h0, byte_sh[7:0]};
        (size_q == 3'b001): lsu_data_o = {{16{half_sh[15]}}, half_sh[15:0]};
        (size_q == 3'b101): lsu_data_o = {16'h0, half_sh[15:0]};
        (size_q == 3'b010): lsu_data_o = data_rdata_i;
        default:            lsu_data_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      offset_q     <= 2'b00;
      size_q       <= 3'b000;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= 32'h0;
      data_wdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        offset_q     <= lsu_addr_i[1:0];
        size_q       <= lsu_size_i;
        data_we_o    <= lsu_we_i;
        data_be_o    <= be_d;
        data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
        data_wdata_o <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb_miriscv_lsu: table-driven load/store vectors with a scoreboard,
// plus hand sequences for illegal size, reset abort and misalignment.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  size = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;
  logic [31:0] ld;
  logic        stall;
  logic        misal;
  logic        dreq;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lsu_req_i        (req),
    .lsu_we_i         (we),
    .lsu_size_i       (size),
    .lsu_addr_i       (addr),
    .lsu_data_i       (wd),
    .lsu_data_o       (ld),
    .lsu_stall_req_o  (stall),
    .lsu_misaligned_o (misal),
    .data_req_o       (dreq),
    .data_gnt_i       (gnt),
    .data_rvalid_i    (rvalid),
    .data_rdata_i     (rdata),
    .data_we_o        (dwe),
    .data_be_o        (dbe),
    .data_addr_o      (daddr),
    .data_wdata_o     (dwdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_wait;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[9];
  vec_t sb[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    chk(n, {31'h0, a}, {31'h0, e});
  endtask

  task automatic run_vec(input vec_t v);
    int   stalls;
    vec_t e;
    stalls = 0;
    @(posedge clk); #1;
    req = 1'b1; we = v.we; size = v.size;
    addr = v.addr; wd = v.wdata;
    gnt = 1'b0; rvalid = 1'b0;
    sb.push_back(v);
    @(negedge clk);
    chk1("idle_req", dreq, 1'b0);
    chk1("idle_misal", misal, 1'b0);
    if (stall) stalls++;
    for (int i = 0; i < v.gnt_wait; i++) begin
      @(posedge clk); #1;
      rvalid = (i == 0);
      @(negedge clk);
      chk1("held_req", dreq, 1'b1);
      chk("held_addr", daddr, v.exp_addr);
      chk("held_be", {28'h0, dbe}, {28'h0, v.exp_be});
      chk("held_wdata", dwdata, v.exp_wdata);
      if (stall) stalls++;
    end
    @(posedge clk); #1;
    rvalid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    chk1("req", dreq, 1'b1);
    chk("addr", daddr, v.exp_addr);
    chk("be", {28'h0, dbe}, {28'h0, v.exp_be});
    chk1("we", dwe, v.we);
    chk("wdata", dwdata, v.exp_wdata);
    chk("data_early", ld, 32'h0);
    if (stall) stalls++;
    @(posedge clk); #1;
    gnt = 1'b0; rvalid = 1'b1; rdata = v.rdata;
    @(negedge clk);
    chk1("wait_req", dreq, 1'b0);
    chk1("done_stall", stall, 1'b0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      chk("load_data", ld, e.exp_data);
    end
    if (stall) stalls++;
    chk("stall_cycles", 32'(stalls), 32'(2 + v.gnt_wait));
    @(posedge clk); #1;
    req = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk("data_after", ld, 32'h0);
    chk1("req_after", dreq, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //             we    sz    addr          wdata         rdata         gw  exp_addr      be       exp_wdata     exp_data
    vecs[0] = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2] = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3] = '{1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[4] = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 0, 32'h0000_0200, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[5] = '{1'b0, 3'd5, 32'h0000_0200, 32'h0,        32'h8001_7FFF, 2, 32'h0000_0200, 4'b0011, 32'h0,        32'h0000_7FFF};
    vecs[6] = '{1'b1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{1'b1, 3'd2, 32'h0000_0400, 32'hCAFE_F00D, 32'h1111_1111, 3, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_007F};

    // reset state
    rst = 1'b1; req = 1'b1;
    @(negedge clk);
    chk1("rst_stall", stall, 1'b1);
    req = 1'b0;
    @(negedge clk);
    chk1("rst_req", dreq, 1'b0);
    chk1("rst_we", dwe, 1'b0);
    chk("rst_be", {28'h0, dbe}, 32'h0);
    chk("rst_addr", daddr, 32'h0);
    chk("rst_wdata", dwdata, 32'h0);
    chk("rst_data", ld, 32'h0);
    chk1("rst_misal", misal, 1'b0);
    chk1("rst_stall0", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // gnt/rvalid ignored in IDLE
    @(posedge clk); #1;
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_rvalid_data", ld, 32'h0);
    @(posedge clk); #1;
    gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk1("idle_gnt_req", dreq, 1'b0);

    // illegal sizes complete immediately
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 3'd3; addr = 32'h100;
    @(negedge clk);
    chk1("ill3_stall", stall, 1'b0);
    chk("ill3_data", ld, 32'h0);
    @(posedge clk); #1;
    size = 3'd7;
    @(negedge clk);
    chk1("ill3_req", dreq, 1'b0);
    chk1("ill7_stall", stall, 1'b0);
    @(posedge clk); #1;
    size = 3'd6;
    @(negedge clk);
    chk1("ill7_req", dreq, 1'b0);
    chk1("ill6_stall", stall, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk1("ill6_req", dreq, 1'b0);

    // reset while in WAIT aborts; late rvalid discarded
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h500;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("abort_stall", stall, 1'b1);
    chk("abort_data0", ld, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk1("abort_req", dreq, 1'b0);
    chk("abort_data", ld, 32'h0);
    chk("abort_addr", daddr, 32'h0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    chk1("abort_req2", dreq, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h101;
    @(negedge clk);
    chk1("mis_flag", misal, 1'b1);
    chk1("mis_stall", stall, 1'b0);
    chk1("mis_req", dreq, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk1("mis_flag_end", misal, 1'b0);
    chk1("mis_req2", dreq, 1'b0);
`else
    run_vec('{1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h1122_3344, 0,
              32'h0000_0100, 4'b1111, 32'h0, 32'h1122_3344});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
